// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands in, result and status flags out.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUctr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Zero;
  logic             Overflow;
  logic             DivZero;
  logic             Illegal;

  modport master (
    output in_valid, A, B, ALUctr, out_ready,
    input  in_ready, out_valid, Result, ResultHi, Zero, Overflow, DivZero, Illegal
  );

  modport slave (
    input  in_valid, A, B, ALUctr, out_ready,
    output in_ready, out_valid, Result, ResultHi, Zero, Overflow, DivZero, Illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus bit-serial multu/divu,
// one operation outstanding, result held until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int HW = WIDTH / 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b1110;
  localparam logic [3:0] OP_SUBU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b0110;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic                    w_accept;
  logic                    w_iter_op;
  logic                    w_iter_last;
  logic [CW-1:0]           r_cnt;
  logic                    r_is_div;
  logic [WIDTH-1:0]        r_acc;
  logic [WIDTH-1:0]        r_lo;
  logic [WIDTH-1:0]        r_opd;
  logic [WIDTH:0]          w_mul_sum;
  logic [WIDTH:0]          w_div_shift;
  logic [WIDTH-1:0]        w_div_diff;
  logic                    w_div_ge;

  logic [WIDTH-1:0]        w_add;
  logic [WIDTH-1:0]        w_sub;
  logic signed [WIDTH-1:0] w_b_s;
  logic [SHW-1:0]          w_shamt;
  logic [WIDTH-1:0]        w_res;
  logic [WIDTH-1:0]        w_hi;
  logic                    w_ovf;
  logic                    w_dz;
  logic                    w_ill;

  logic [WIDTH-1:0]        r_result;
  logic [WIDTH-1:0]        r_result_hi;
  logic                    r_zero;
  logic                    r_ovf;
  logic                    r_dz;
  logic                    r_ill;

  // Two's-complement overflow of a+b given the sign bits; sub passes ~b's sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_accept    = bus.in_valid && (r_state == S_IDLE);
  assign w_iter_op   = (bus.ALUctr == OP_MULTU) || ((bus.ALUctr == OP_DIVU) && (bus.B != '0));
  assign w_iter_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = w_iter_op ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_iter_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_add   = bus.A + bus.B;
    w_sub   = bus.A - bus.B;
    w_b_s   = bus.B;
    w_shamt = bus.A[SHW-1:0];
    w_res   = '0;
    w_hi    = '0;
    w_ovf   = 1'b0;
    w_dz    = 1'b0;
    w_ill   = 1'b0;
    case (bus.ALUctr)
      OP_ADDU: w_res = w_add;
      OP_ADD: begin
        w_res = w_add;
        w_ovf = add_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1], w_add[WIDTH-1]);
      end
      OP_SUBU: w_res = w_sub;
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = add_ovf(bus.A[WIDTH-1], ~bus.B[WIDTH-1], w_sub[WIDTH-1]);
      end
      OP_AND:   w_res = bus.A & bus.B;
      OP_OR:    w_res = bus.A | bus.B;
      OP_XOR:   w_res = bus.A ^ bus.B;
      OP_SLL:   w_res = bus.B << w_shamt;
      OP_SRL:   w_res = bus.B >> w_shamt;
      OP_SRA:   w_res = w_b_s >>> w_shamt;
      OP_LUI:   w_res = {bus.B[HW-1:0], {HW{1'b0}}};
      OP_MULTU: w_res = '0;
      OP_DIVU: begin
        // Only the divide-by-zero case completes here; real divides iterate.
        w_res = '1;
        w_hi  = bus.A;
        w_dz  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Bit-serial step: multu adds then shifts right into {acc,lo};
  // divu shifts the dividend into acc and subtracts the divisor when it fits.
  assign w_mul_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_acc, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_cnt <= '0;
    else if (w_accept)                          r_cnt <= '0;
    else if (r_state == S_BUSY && !w_iter_last) r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= (bus.ALUctr == OP_DIVU);
      r_acc    <= '0;
      r_lo     <= (bus.ALUctr == OP_DIVU) ? bus.A : bus.B;
      r_opd    <= (bus.ALUctr == OP_DIVU) ? bus.B : bus.A;
    end else if (r_state == S_BUSY && !w_iter_last) begin
      if (r_is_div) begin
        r_acc <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
      end else begin
        r_acc <= w_mul_sum[WIDTH:1];
        r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end else if (w_accept && !w_iter_op) begin
      r_result    <= w_res;
      r_result_hi <= w_hi;
      r_zero      <= ~|w_res;
      r_ovf       <= w_ovf;
      r_dz        <= w_dz;
      r_ill       <= w_ill;
    end else if (r_state == S_BUSY && w_iter_last) begin
      r_result    <= r_lo;
      r_result_hi <= r_acc;
      r_zero      <= ~|r_lo;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end else if (r_state == S_DONE && bus.out_ready) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end
  end

  assign bus.Result   = r_result;
  assign bus.ResultHi = r_result_hi;
  assign bus.Zero     = r_zero;
  assign bus.Overflow = r_ovf;
  assign bus.DivZero  = r_dz;
  assign bus.Illegal  = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq; a 32-bit and an 8-bit instance run
// the same operations side by side against an arithmetic reference model.
module tb_alu_seq;
  localparam logic [3:0] OP_ADDU  = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b1110;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SUBU  = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b0110;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] cap_res[2];
  logic [63:0] cap_hi[2];
  logic [3:0]  cap_flg[2];  // {Zero, Overflow, DivZero, Illegal}
  int          cap_lat[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_op(input logic [3:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input int w, output logic [63:0] res, output logic [63:0] hi,
                                 output logic [3:0] flg, output int lat);
    logic [63:0]        mask, a, b;
    logic [127:0]       prod;
    logic signed [66:0] sa, sb, s, lim;
    logic               ovf, dz, ill;
    int                 sh;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = $signed({3'b000, a});
    sb = $signed({3'b000, b});
    if (a[w-1]) sa = sa - (67'sd1 <<< w);
    if (b[w-1]) sb = sb - (67'sd1 <<< w);
    lim = 67'sd1 <<< (w - 1);
    sh  = int'(a % 64'(w));
    res = '0; hi = '0; ovf = 1'b0; dz = 1'b0; ill = 1'b0; lat = 1;
    case (op)
      OP_ADDU: res = a + b;
      OP_ADD:  begin s = sa + sb; res = s[63:0]; ovf = (s >= lim) || (s < -lim); end
      OP_SUBU: res = a - b;
      OP_SUB:  begin s = sa - sb; res = s[63:0]; ovf = (s >= lim) || (s < -lim); end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = b << sh;
      OP_SRL:  res = b >> sh;
      OP_SRA:  begin s = sb >>> sh; res = s[63:0]; end
      OP_LUI:  res = (b & (mask >> (w / 2))) << (w / 2);
      OP_MULTU: begin
        prod = {64'd0, a} * {64'd0, b};
        res = prod[63:0];
        hi  = 64'(prod >> w);
        lat = w + 1;
      end
      OP_DIVU: begin
        if (b == 0) begin res = mask; hi = a; dz = 1'b1; end
        else begin res = a / b; hi = a % b; lat = w + 1; end
      end
      default: ill = 1'b1;
    endcase
    res = res & mask;
    hi  = hi & mask;
    flg = {res == 64'd0, ovf, dz, ill};
  endfunction

  task automatic drive_idle();
    b32.in_valid = 1'b0; b32.A = '0; b32.B = '0; b32.ALUctr = '0; b32.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.ALUctr  = '0; b8.out_ready  = 1'b0;
  endtask

  // Issue one op to both instances, wait for each result, check, then release.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] e_res, e_hi;
    logic [3:0]  e_flg;
    int          e_lat, w, busy_rdy;
    bit          got[2];
    string       tag;
    @(negedge clk);
    chk("idle in_ready32", 64'(b32.in_ready), 64'd1);
    chk("idle in_ready8", 64'(b8.in_ready), 64'd1);
    b32.in_valid = 1'b1; b32.A = a[31:0]; b32.B = b[31:0]; b32.ALUctr = op;
    b8.in_valid  = 1'b1; b8.A  = a[7:0];  b8.B  = b[7:0];  b8.ALUctr  = op;
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b8.in_valid = 1'b0;
    got[0] = 1'b0; got[1] = 1'b0; busy_rdy = 0;
    for (int k = 1; k <= 80 && !(got[0] && got[1]); k++) begin
      @(posedge clk); #1;
      if (!got[0] && b32.in_ready) busy_rdy++;
      if (!got[0] && b32.out_valid) begin
        got[0] = 1'b1; cap_lat[0] = k;
        cap_res[0] = 64'(b32.Result); cap_hi[0] = 64'(b32.ResultHi);
        cap_flg[0] = {b32.Zero, b32.Overflow, b32.DivZero, b32.Illegal};
      end
      if (!got[1] && b8.out_valid) begin
        got[1] = 1'b1; cap_lat[1] = k;
        cap_res[1] = 64'(b8.Result); cap_hi[1] = 64'(b8.ResultHi);
        cap_flg[1] = {b8.Zero, b8.Overflow, b8.DivZero, b8.Illegal};
      end
    end
    chk($sformatf("op%b in_ready while pending", op), 64'(busy_rdy), 64'd0);
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 32 : 8;
      ref_op(op, a, b, w, e_res, e_hi, e_flg, e_lat);
      tag = $sformatf("op%b w%0d a=%h b=%h", op, w, a, b);
      chk($sformatf("%s done", tag), 64'(got[i]), 64'd1);
      if (got[i]) begin
        chk($sformatf("%s latency", tag), 64'(cap_lat[i]), 64'(e_lat));
        chk($sformatf("%s Result", tag), cap_res[i], e_res);
        chk($sformatf("%s ResultHi", tag), cap_hi[i], e_hi);
        chk($sformatf("%s flags", tag), 64'(cap_flg[i]), 64'(e_flg));
      end
    end
    @(negedge clk);
    b32.out_ready = 1'b1; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0; b8.out_ready = 1'b0;
    chk("release out_valid32", 64'(b32.out_valid), 64'd0);
    chk("release in_ready32", 64'(b32.in_ready), 64'd1);
    chk("release cleared32", {b32.Result, b32.ResultHi}, 64'd0);
    chk("release out_valid8", 64'(b8.out_valid), 64'd0);
    chk("release cleared8", {40'd0, b8.Result, b8.ResultHi, b8.Zero, b8.Overflow, b8.DivZero,
                             b8.Illegal, 4'd0}, 64'd0);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (b32.out_valid || b8.out_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk($sformatf("%s in_ready", tag), {62'd0, b32.in_ready, b8.in_ready}, 64'd3);
    chk($sformatf("%s out_valid", tag), {62'd0, b32.out_valid, b8.out_valid}, 64'd0);
    chk($sformatf("%s result32", tag), {b32.Result, b32.ResultHi}, 64'd0);
    chk($sformatf("%s result8", tag), {48'd0, b8.Result, b8.ResultHi}, 64'd0);
    chk($sformatf("%s flags", tag), {56'd0, b32.Zero, b32.Overflow, b32.DivZero, b32.Illegal,
                                     b8.Zero, b8.Overflow, b8.DivZero, b8.Illegal}, 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF;
      2:       return 64'h8000_0000;
      3:       return 64'h7FFF_FFFF;
      4:       return 64'h80;
      5:       return 64'h7F;
      default: return {32'd0, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-derived answers.
    run_op(OP_ADD, 64'h7FFF_FFFF, 64'h1);
    chk("add ovf Result", cap_res[0], 64'h8000_0000);
    chk("add ovf flags", 64'(cap_flg[0]), 64'b0100);
    chk("add ovf latency", 64'(cap_lat[0]), 64'd1);

    run_op(OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    chk("multu32 {Hi,Lo}", {cap_hi[0][31:0], cap_res[0][31:0]}, 64'hFFFF_FFFE_0000_0001);
    chk("multu32 latency", 64'(cap_lat[0]), 64'd33);
    chk("multu8 {Hi,Lo}", {cap_hi[1][7:0], cap_res[1][7:0]}, 64'hFE01);
    chk("multu8 latency", 64'(cap_lat[1]), 64'd9);

    run_op(OP_DIVU, 64'h100, 64'h7);
    chk("divu Result", cap_res[0], 64'h24);
    chk("divu ResultHi", cap_hi[0], 64'h4);
    chk("divu latency", 64'(cap_lat[0]), 64'd33);

    run_op(OP_DIVU, 64'h1234_5678, 64'h0);
    chk("divu0 Result", cap_res[0], 64'hFFFF_FFFF);
    chk("divu0 ResultHi", cap_hi[0], 64'h1234_5678);
    chk("divu0 flags", 64'(cap_flg[0]), 64'b0010);
    chk("divu0 latency", 64'(cap_lat[0]), 64'd1);

    run_op(OP_SRA, 64'h4, 64'h8000_0000);
    chk("sra Result", cap_res[0], 64'hF800_0000);

    run_op(4'b1111, 64'h55, 64'hAA);
    chk("illegal flags", 64'(cap_flg[0]), 64'b1001);
    chk("illegal Result", cap_res[0], 64'd0);

    run_op(OP_LUI, 64'h0, 64'hDEAD_BEEF);
    chk("lui Result", cap_res[0], 64'hBEEF_0000);

    // Randomized sweep over every opcode, including undefined ones.
    repeat (48) begin
      op = 4'($urandom_range(0, 15));
      a = pick();
      b = ($urandom_range(0, 5) == 0) ? 64'h0 : pick();
      run_op(op, a, b);
    end

    // Result must hold while out_ready is low; requests during DONE are not taken.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.A = 32'd5; b32.B = 32'd6; b32.ALUctr = OP_ADDU;
    @(posedge clk); #1;
    b32.A = 32'd100; b32.B = 32'd3; b32.ALUctr = OP_MULTU;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d Result", i), 64'(b32.Result), 64'd11);
      chk($sformatf("hold%0d out_valid", i), 64'(b32.out_valid), 64'd1);
      chk($sformatf("hold%0d in_ready", i), 64'(b32.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    chk("hold release in_ready", 64'(b32.in_ready), 64'd1);
    watch_quiet("hold no stray accept", 40);

    // Reset in DONE clears outputs at once.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.A = 32'd3; b32.B = 32'd4; b32.ALUctr = OP_ADDU;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    chk("pre-reset Result", 64'(b32.Result), 64'd7);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("reset in DONE");
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("after DONE reset quiet", 40);

    // Reset at cycle 10 of multu: 32-bit is BUSY, 8-bit already DONE.
    @(negedge clk);
    b32.in_valid = 1'b1; b32.A = 32'hFFFF_FFFF; b32.B = 32'hFFFF_FFFF; b32.ALUctr = OP_MULTU;
    b8.in_valid  = 1'b1; b8.A  = 8'hFF;         b8.B  = 8'hFF;         b8.ALUctr  = OP_MULTU;
    @(posedge clk); #1;
    b32.in_valid = 1'b0; b8.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset multu8 done", {55'd0, b8.out_valid, b8.Result}, {55'd1, 8'h01, 8'h00} >> 8);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("reset in BUSY");
    @(negedge clk);
    rst_n = 1'b1;
    // First accept on the first rising edge after release.
    b32.in_valid = 1'b1; b32.A = 32'd9; b32.B = 32'd1; b32.ALUctr = OP_SUBU;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    chk("post-reset accept out_valid", 64'(b32.out_valid), 64'd1);
    chk("post-reset accept Result", 64'(b32.Result), 64'd8);
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    watch_quiet("after BUSY reset quiet", 40);

    run_op(OP_SUB, 64'h8000_0000, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
